// File: rtl/lut_mem_scanner.sv
// Writable lookup memory with registered read, timed auto-scan and hold.
// Replaces the fixed switch-addressed LED lookup in top.
module lut_mem_scanner #(
    parameter int NBITS_DATA = 4,
    parameter int NBITS_ADDR = 2,
    parameter int SCAN_DIV   = 4,
    parameter int INIT_XOR   = 'h3
) (
    input  logic                  clk_2,
    input  logic                  reset,
    input  logic [1:0]            mode,
    input  logic [NBITS_ADDR-1:0] addr,
    input  logic [NBITS_DATA-1:0] wdata,
    output logic [NBITS_DATA-1:0] data_out,
    output logic [NBITS_ADDR-1:0] addr_out,
    output logic                  valid,
    output logic                  wr_ack
);

    localparam int DEPTH = 2 ** NBITS_ADDR;
    localparam int DIV_W = $clog2(SCAN_DIV) + 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);

    typedef enum logic [1:0] {
        M_READ  = 2'b00,
        M_WRITE = 2'b01,
        M_SCAN  = 2'b10,
        M_HOLD  = 2'b11
    } mode_t;

    logic [NBITS_DATA-1:0] mem [DEPTH];
    logic [NBITS_ADDR-1:0] scan_ptr;
    logic [NBITS_ADDR-1:0] ptr_eff;
    logic [NBITS_ADDR-1:0] ptr_nxt;
    logic [DIV_W-1:0]      div_cnt;
    logic [DIV_W-1:0]      div_eff;
    logic [DIV_W-1:0]      div_nxt;
    logic                  restart;
    mode_t                 cur_mode;
    mode_t                 prev_mode;

    assign cur_mode = mode_t'(mode);

    // A scan entered from READ/WRITE restarts at entry 0; from HOLD it resumes.
    always_comb begin
        restart = (prev_mode == M_READ) || (prev_mode == M_WRITE);
        ptr_eff = restart ? '0 : scan_ptr;
        div_eff = restart ? '0 : div_cnt;
        ptr_nxt = ptr_eff;
        div_nxt = div_eff + DIV_W'(1);
        if (div_eff == DIV_LAST) begin
            ptr_nxt = ptr_eff + NBITS_ADDR'(1);
            div_nxt = '0;
        end
    end

    always_ff @(posedge clk_2) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[NBITS_ADDR'(i)] <= NBITS_DATA'(i) ^ NBITS_DATA'(INIT_XOR);
            end
            data_out  <= '0;
            addr_out  <= '0;
            valid     <= 1'b0;
            wr_ack    <= 1'b0;
            scan_ptr  <= '0;
            div_cnt   <= '0;
            prev_mode <= M_HOLD;
        end else begin
            prev_mode <= cur_mode;
            unique case (cur_mode)
                M_READ: begin
                    data_out <= mem[addr];
                    addr_out <= addr;
                    valid    <= 1'b1;
                    wr_ack   <= 1'b0;
                end
                M_WRITE: begin
                    mem[addr] <= wdata;
                    data_out  <= wdata;
                    addr_out  <= addr;
                    valid     <= 1'b1;
                    wr_ack    <= 1'b1;
                end
                M_SCAN: begin
                    data_out <= mem[ptr_eff];
                    addr_out <= ptr_eff;
                    valid    <= 1'b1;
                    wr_ack   <= 1'b0;
                    scan_ptr <= ptr_nxt;
                    div_cnt  <= div_nxt;
                end
                M_HOLD: begin
                    valid  <= 1'b0;
                    wr_ack <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lut_mem_scanner.sv
// Randomized and directed bench for lut_mem_scanner against a
// scan-position reference model; second instance covers an 8x8, div-1 build.
module tb_lut_mem_scanner;

    localparam int DW    = 4;
    localparam int AW    = 2;
    localparam int DIV   = 4;
    localparam int DEPTH = 4;
    localparam int XORV  = 'h3;

    localparam int READ  = 0;
    localparam int WRITE = 1;
    localparam int SCAN  = 2;
    localparam int HOLD  = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset;
    logic [1:0]    mode;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] data_out;
    logic [AW-1:0] addr_out;
    logic          valid;
    logic          wr_ack;

    logic       reset2;
    logic [1:0] mode2;
    logic [2:0] addr2;
    logic [7:0] wdata2;
    logic [7:0] data_out2;
    logic [2:0] addr_out2;
    logic       valid2;
    logic       wr_ack2;

    lut_mem_scanner u_dut (
        .clk_2    (clk),
        .reset    (reset),
        .mode     (mode),
        .addr     (addr),
        .wdata    (wdata),
        .data_out (data_out),
        .addr_out (addr_out),
        .valid    (valid),
        .wr_ack   (wr_ack)
    );

    lut_mem_scanner #(
        .NBITS_DATA (8),
        .NBITS_ADDR (3),
        .SCAN_DIV   (1),
        .INIT_XOR   ('h3)
    ) u_dut8 (
        .clk_2    (clk),
        .reset    (reset2),
        .mode     (mode2),
        .addr     (addr2),
        .wdata    (wdata2),
        .data_out (data_out2),
        .addr_out (addr_out2),
        .valid    (valid2),
        .wr_ack   (wr_ack2)
    );

    int errors = 0;
    int checks = 0;

    int m_mem [DEPTH];
    int m_dout;
    int m_aout;
    int m_valid;
    int m_ack;
    int m_pos;
    int m_prev;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Scan position counts edges spent scanning; entry = (pos / DIV) mod DEPTH.
    task automatic model(input bit r, input int m, input int a, input int d);
        if (r) begin
            for (int i = 0; i < DEPTH; i++) m_mem[i] = (i ^ XORV) & 'hF;
            m_dout  = 0;
            m_aout  = 0;
            m_valid = 0;
            m_ack   = 0;
            m_pos   = 0;
            m_prev  = HOLD;
            return;
        end
        case (m)
            READ: begin
                m_dout  = m_mem[a];
                m_aout  = a;
                m_valid = 1;
                m_ack   = 0;
            end
            WRITE: begin
                m_mem[a] = d;
                m_dout   = d;
                m_aout   = a;
                m_valid  = 1;
                m_ack    = 1;
            end
            SCAN: begin
                if (m_prev == READ || m_prev == WRITE) m_pos = 0;
                m_aout  = (m_pos / DIV) % DEPTH;
                m_dout  = m_mem[m_aout];
                m_valid = 1;
                m_ack   = 0;
                m_pos++;
            end
            default: begin
                m_valid = 0;
                m_ack   = 0;
            end
        endcase
        m_prev = m;
    endtask

    task automatic step(input bit r, input int m, input int a, input int d);
        int am;
        int dm;
        am = a & (DEPTH - 1);
        dm = d & 'hF;
        @(negedge clk);
        reset = r;
        mode  = m[1:0];
        addr  = am[AW-1:0];
        wdata = dm[DW-1:0];
        @(posedge clk);
        model(r, m, am, dm);
        #1;
        chk("data_out", {28'd0, data_out}, m_dout);
        chk("addr_out", {30'd0, addr_out}, m_aout);
        chk("valid", {31'd0, valid}, m_valid);
        chk("wr_ack", {31'd0, wr_ack}, m_ack);
    endtask

    task automatic step8(input bit r, input int m, input int a);
        @(negedge clk);
        reset2 = r;
        mode2  = m[1:0];
        addr2  = a[2:0];
        wdata2 = 8'h00;
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset  = 1'b1;
        mode   = 2'b11;
        addr   = '0;
        wdata  = '0;
        reset2 = 1'b1;
        mode2  = 2'b11;
        addr2  = '0;
        wdata2 = '0;

        step(1, HOLD, 0, 0);
        chk("rst_valid", {31'd0, valid}, 0);

        for (int i = 0; i < 4; i++) begin
            step(0, READ, i, 0);
            chk("read_init", {28'd0, data_out}, 3 - i);
        end

        step(0, WRITE, 2, 9);
        chk("wr_data", {28'd0, data_out}, 9);
        step(0, READ, 2, 0);
        chk("rd_after_wr", {28'd0, data_out}, 9);
        chk("ack_one_cycle", {31'd0, wr_ack}, 0);

        for (int k = 0; k < 20; k++) begin
            step(0, SCAN, 0, 0);
            chk("scan_seq", {30'd0, addr_out}, (k / 4) % 4);
        end

        step(0, READ, 0, 0);
        for (int k = 0; k < 6; k++) step(0, SCAN, 0, 0);
        chk("scan6_addr", {30'd0, addr_out}, 1);
        for (int k = 0; k < 5; k++) begin
            step(0, HOLD, 3, 5);
            chk("hold_addr", {30'd0, addr_out}, 1);
        end
        for (int k = 0; k < 2; k++) begin
            step(0, SCAN, 0, 0);
            chk("resume_e1", {30'd0, addr_out}, 1);
        end
        step(0, SCAN, 0, 0);
        chk("resume_e2", {30'd0, addr_out}, 2);

        step(0, READ, 0, 0);
        for (int k = 0; k < 6; k++) step(0, SCAN, 0, 0);
        step(1, WRITE, 0, 'hF);
        chk("rst_mid_scan", {31'd0, valid}, 0);
        for (int k = 0; k < 3; k++) begin
            step(0, SCAN, 0, 0);
            chk("scan_after_rst", {30'd0, addr_out}, 0);
        end
        step(0, READ, 0, 0);
        chk("write_lost", {28'd0, data_out}, 3);

        for (int k = 0; k < 400; k++) begin
            step($urandom_range(0, 39) == 0, $urandom_range(0, 3),
                 $urandom, $urandom);
        end

        step8(1, HOLD, 0);
        chk("w8_rst_data", {24'd0, data_out2}, 0);
        chk("w8_rst_valid", {31'd0, valid2}, 0);
        for (int i = 0; i < 8; i++) begin
            step8(0, READ, i);
            chk("w8_init", {24'd0, data_out2}, i ^ 'h3);
        end
        for (int k = 0; k < 10; k++) begin
            step8(0, SCAN, 0);
            chk("w8_scan_addr", {29'd0, addr_out2}, k % 8);
            chk("w8_scan_data", {24'd0, data_out2}, (k % 8) ^ 'h3);
        end
        chk("w8_ack", {31'd0, wr_ack2}, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
